pilha: RTL and testbench
========================

# pilha

Hardware LIFO operand stack for the stack processor: the responder side of the `UC` stack command interface.
- `UC` issues one-cycle commands on `pilha_wren`/`controle_pilha`/`data_pilha`.
- The stack executes them and returns the two top entries to the ALU temporary registers.
- Status and a completion pulse flow back to `UC`.

## Interface
Parameters:
- `DATA_W`, 16, entry width (matches `data_pilha`/`data_mem`).
- `DEPTH`, 16, number of entries; power of two, ≥ 4.
- `CNT_W`, `$clog2(DEPTH)+1`, width of the occupancy count.

Ports:
- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pilha_wren`  in  1  command strobe; one command per cycle while high.
- `controle_pilha`  in  2  command code:
  - 00 POP
  - 01 PUSH
  - 10 SUBST (overwrite top)
  - 11 REDUZ (pop two, push `data_pilha`)
- `data_pilha`  in  DATA_W  write data for PUSH/SUBST/REDUZ.
- `topo`  out  DATA_W  current top entry; 0 when empty.
- `segundo`  out  DATA_W  entry below top; 0 when count < 2.
- `contagem`  out  CNT_W  number of valid entries, 0..DEPTH.
- `vazia`  out  1  `contagem` == 0.
- `cheia`  out  1  `contagem` == DEPTH.
- `pronto`  out  1  one-cycle pulse: previous-cycle command executed.
- `erro`  out  1  sticky: an illegal command was rejected.
- `limpa_erro`  in  1  synchronous clear of `erro`.

## Operation
- Storage: DEPTH×DATA_W register array, write index = `contagem`, top index = `contagem`−1.
- PUSH: legal if not `cheia`. Writes `data_pilha` at index `contagem`; `contagem`+1.
- POP: legal if not `vazia`. `contagem`−1; the popped entry is not cleared.
- SUBST: legal if `contagem` ≥ 1. Overwrites the top entry; `contagem` unchanged.
- REDUZ: legal if `contagem` ≥ 2. Writes `data_pilha` at index `contagem`−2; `contagem`−1. This is the binary ALU result path.
- Illegal command (PUSH when full, POP when empty, SUBST when empty, REDUZ with count < 2):
  - no storage or count change;
  - `erro` set;
  - `pronto` not pulsed.
- `pilha_wren` low: no action; `controle_pilha`/`data_pilha` are don't-care.
- `limpa_erro` with a simultaneous illegal command: the set wins, so `erro` stays 1.
- No wrap-around: the count saturates by rejection, never modulo.
- FSM: two states.
  - OCIOSO: idle, `pronto`=0.
  - EXEC: `pronto`=1 for one cycle.
  - OCIOSO→EXEC on a legal command.
  - EXEC→EXEC on another legal command (back-to-back allowed, `pronto` stays high).
  - EXEC→OCIOSO otherwise.

## Timing
- Command sampled on rising edge with `pilha_wren`=1. `topo`, `segundo`, `contagem`, `vazia`, `cheia` reflect the result from the following cycle (latency 1).
- `pronto` is high in the cycle after the executing edge, coincident with the updated outputs.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Reset (asynchronous assert, synchronous deassert by the system) drives:
  - `contagem`=0, `vazia`=1, `cheia`=0, `topo`=0, `segundo`=0, `pronto`=0, `erro`=0, FSM=OCIOSO.
  - Array contents are don't-care.
- Reset asserted mid-command: the command is discarded, outputs take reset values immediately, and no `pronto` follows.

## Structure
- Package `pilha_pkg`:
  - command encodings `OP_POP`, `OP_PUSH`, `OP_SUBST`, `OP_REDUZ`;
  - FSM state typedef (`OCIOSO`, `EXEC`);
  - default `DATA_W`/`DEPTH`.
- Sub-module `pilha_mem`: register array with one write port and two asynchronous read ports (top, second), no reset on data.
- Top level `pilha` holds the count, legality check, FSM and status flags.

## Test plan
- After reset, PUSH 0x0005 then PUSH 0x000A:
  - `contagem`=2, `topo`=0x000A, `segundo`=0x0005;
  - `pronto` high 2 consecutive cycles.
- From {0x0005, 0x000A}, REDUZ with 0x000F: `contagem`=1, `topo`=0x000F, `segundo`=0.
- 16 PUSHes of 0x0001..0x0010:
  - `cheia`=1, `topo`=0x0010;
  - a 17th PUSH of 0xFFFF leaves `topo`=0x0010 and `contagem`=16, sets `erro`, gives no `pronto`.
- POP on empty stack: `erro`=1, `vazia` stays 1. Then `limpa_erro` for 1 cycle: `erro`=0.
- SUBST 0x1234 on {0x0007}: `topo`=0x1234, `contagem`=1. Then REDUZ: rejected, `erro`=1.
- Reset pulled low while a PUSH is sampled with 3 entries: all outputs at reset values within the same cycle, no `pronto` after release.

Source files
------------

// File: rtl/pilha_pkg.sv
// Shared definitions for the pilha operand stack: command codes, FSM states
// and default geometry.
package pilha_pkg;

  localparam int PILHA_DATA_W = 16;
  localparam int PILHA_DEPTH  = 16;

  typedef enum logic [1:0] {
    OP_POP   = 2'b00,
    OP_PUSH  = 2'b01,
    OP_SUBST = 2'b10,
    OP_REDUZ = 2'b11
  } op_e;

  typedef enum logic {
    OCIOSO = 1'b0,
    EXEC   = 1'b1
  } estado_e;

endpackage

// File: rtl/pilha_mem.sv
// Stack storage: one synchronous write port, two asynchronous read ports for
// the top and second entries. Data is intentionally not reset.
module pilha_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Single write port
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/pilha.sv
// LIFO operand stack answering UC commands: count, legality check, completion
// FSM and sticky error flag around a register-array store.
module pilha
  import pilha_pkg::*;
#(
  parameter int DATA_W = PILHA_DATA_W,
  parameter int DEPTH  = PILHA_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pilha_wren,
  input  logic [1:0]        controle_pilha,
  input  logic [DATA_W-1:0] data_pilha,
  input  logic              limpa_erro,
  output logic [DATA_W-1:0] topo,
  output logic [DATA_W-1:0] segundo,
  output logic [CNT_W-1:0]  contagem,
  output logic              vazia,
  output logic              cheia,
  output logic              pronto,
  output logic              erro
);

  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0]  contagem_q, contagem_d;
  estado_e           estado_q, estado_d;
  logic              erro_q, erro_d;

  logic              legal_s;
  logic              wr_en_s;
  logic [AW-1:0]     wr_addr_s;
  logic [AW-1:0]     base_idx_s;
  logic [AW-1:0]     topo_idx_s;
  logic [AW-1:0]     seg_idx_s;
  logic              tem_um_s;
  logic              tem_dois_s;
  logic              cheia_s;
  logic [DATA_W-1:0] rd_topo_s;
  logic [DATA_W-1:0] rd_seg_s;

  // Index arithmetic is modulo DEPTH; a full count of DEPTH wraps to 0 in the
  // low bits, so DEPTH-1 still addresses the top correctly.
  assign base_idx_s = contagem_q[AW-1:0];
  assign topo_idx_s = base_idx_s - AW'(1);
  assign seg_idx_s  = base_idx_s - AW'(2);
  assign tem_um_s   = (contagem_q != CNT_W'(0));
  assign tem_dois_s = (contagem_q >= CNT_W'(2));
  assign cheia_s    = (contagem_q == CNT_W'(DEPTH));

  // Command decode: legality, write port control and next count
  always_comb begin
    legal_s    = 1'b0;
    wr_en_s    = 1'b0;
    wr_addr_s  = base_idx_s;
    contagem_d = contagem_q;
    if (pilha_wren) begin
      case (op_e'(controle_pilha))
        OP_PUSH: begin
          if (!cheia_s) begin
            legal_s    = 1'b1;
            wr_en_s    = 1'b1;
            wr_addr_s  = base_idx_s;
            contagem_d = contagem_q + CNT_W'(1);
          end else begin
            legal_s = 1'b0;
          end
        end
        OP_POP: begin
          if (tem_um_s) begin
            legal_s    = 1'b1;
            contagem_d = contagem_q - CNT_W'(1);
          end else begin
            legal_s = 1'b0;
          end
        end
        OP_SUBST: begin
          if (tem_um_s) begin
            legal_s   = 1'b1;
            wr_en_s   = 1'b1;
            wr_addr_s = topo_idx_s;
          end else begin
            legal_s = 1'b0;
          end
        end
        OP_REDUZ: begin
          if (tem_dois_s) begin
            legal_s    = 1'b1;
            wr_en_s    = 1'b1;
            wr_addr_s  = seg_idx_s;
            contagem_d = contagem_q - CNT_W'(1);
          end else begin
            legal_s = 1'b0;
          end
        end
        default: legal_s = 1'b0;
      endcase
    end else begin
      legal_s = 1'b0;
    end
  end

  // Error flag: a rejected command beats a simultaneous clear
  always_comb begin
    erro_d = erro_q;
    if (pilha_wren && !legal_s) begin
      erro_d = 1'b1;
    end else if (limpa_erro) begin
      erro_d = 1'b0;
    end else begin
      erro_d = erro_q;
    end
  end

  // FSM next state: EXEC holds for every cycle following a legal command
  always_comb begin
    estado_d = OCIOSO;
    case (estado_q)
      OCIOSO:  estado_d = legal_s ? EXEC : OCIOSO;
      EXEC:    estado_d = legal_s ? EXEC : OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem_q <= CNT_W'(0);
      estado_q   <= OCIOSO;
      erro_q     <= 1'b0;
    end else begin
      contagem_q <= contagem_d;
      estado_q   <= estado_d;
      erro_q     <= erro_d;
    end
  end

  pilha_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clock     (clock),
    .wr_en     (wr_en_s),
    .wr_addr   (wr_addr_s),
    .wr_data   (data_pilha),
    .rd_addr_a (topo_idx_s),
    .rd_addr_b (seg_idx_s),
    .rd_data_a (rd_topo_s),
    .rd_data_b (rd_seg_s)
  );

  assign topo     = tem_um_s   ? rd_topo_s : {DATA_W{1'b0}};
  assign segundo  = tem_dois_s ? rd_seg_s  : {DATA_W{1'b0}};
  assign contagem = contagem_q;
  assign vazia    = !tem_um_s;
  assign cheia    = cheia_s;
  assign pronto   = (estado_q == EXEC);
  assign erro     = erro_q;

endmodule

// File: tb/tb_pilha.sv
// Scoreboard bench for pilha: directed commands queue hand-computed results,
// a monitor compares them on every pronto pulse.
module tb_pilha;

  localparam logic [1:0] C_POP   = 2'b00;
  localparam logic [1:0] C_PUSH  = 2'b01;
  localparam logic [1:0] C_SUBST = 2'b10;
  localparam logic [1:0] C_REDUZ = 2'b11;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pilha_wren = 1'b0;
  logic [1:0]  controle_pilha = 2'b00;
  logic [15:0] data_pilha = 16'h0000;
  logic        limpa_erro = 1'b0;
  logic [15:0] topo, segundo;
  logic [4:0]  contagem;
  logic        vazia, cheia, pronto, erro;

  typedef struct {
    logic [15:0] topo;
    logic [15:0] seg;
    logic [4:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pilha dut (
    .clock          (clock),
    .reset          (reset),
    .pilha_wren     (pilha_wren),
    .controle_pilha (controle_pilha),
    .data_pilha     (data_pilha),
    .limpa_erro     (limpa_erro),
    .topo           (topo),
    .segundo        (segundo),
    .contagem       (contagem),
    .vazia          (vazia),
    .cheia          (cheia),
    .pronto         (pronto),
    .erro           (erro)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every pronto pulse must match the oldest queued expectation
  always @(negedge clock) begin
    if (pronto === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pronto", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("topo", {16'h0, topo}, {16'h0, e.topo});
        chk("segundo", {16'h0, segundo}, {16'h0, e.seg});
        chk("contagem", {27'h0, contagem}, {27'h0, e.cnt});
        chk("vazia", {31'h0, vazia}, {31'h0, (e.cnt == 5'd0)});
        chk("cheia", {31'h0, cheia}, {31'h0, (e.cnt == 5'd16)});
      end
    end
  end

  // Legal command: queue expectation, leave strobe high for back-to-back use
  task automatic cmd_ok(input logic [1:0] op, input logic [15:0] d,
                        input logic [15:0] et, input logic [15:0] es, input logic [4:0] ec);
    exp_t e;
    @(negedge clock);
    pilha_wren = 1'b1; controle_pilha = op; data_pilha = d; limpa_erro = 1'b0;
    e.topo = et; e.seg = es; e.cnt = ec;
    exp_q.push_back(e);
    @(posedge clock);
  endtask

  // Illegal command: nothing queued, state must be unchanged and erro set
  task automatic cmd_bad(input logic [1:0] op, input logic [15:0] d, input logic clr,
                         input logic [15:0] et, input logic [4:0] ec);
    @(negedge clock);
    pilha_wren = 1'b1; controle_pilha = op; data_pilha = d; limpa_erro = clr;
    @(posedge clock);
    @(negedge clock);
    pilha_wren = 1'b0; limpa_erro = 1'b0;
    chk("bad_erro", {31'h0, erro}, 32'd1);
    chk("bad_pronto", {31'h0, pronto}, 32'd0);
    chk("bad_cnt", {27'h0, contagem}, {27'h0, ec});
    chk("bad_topo", {16'h0, topo}, {16'h0, et});
  endtask

  task automatic idle_drain(input string name);
    @(negedge clock);
    pilha_wren = 1'b0; controle_pilha = C_PUSH; data_pilha = 16'hFFFF;
    repeat (2) @(negedge clock);
    chk(name, exp_q.size(), 32'd0);
  endtask

  task automatic clear_err();
    @(negedge clock);
    pilha_wren = 1'b0; limpa_erro = 1'b1;
    @(negedge clock);
    limpa_erro = 1'b0;
    chk("erro_clear", {31'h0, erro}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_cnt", {27'h0, contagem}, 32'd0);
    chk("rst_vazia", {31'h0, vazia}, 32'd1);
    chk("rst_cheia", {31'h0, cheia}, 32'd0);
    chk("rst_topo", {16'h0, topo}, 32'd0);
    chk("rst_seg", {16'h0, segundo}, 32'd0);
    chk("rst_pronto", {31'h0, pronto}, 32'd0);
    chk("rst_erro", {31'h0, erro}, 32'd0);
    reset = 1'b1;

    // Two back-to-back pushes, then the ALU reduce path
    cmd_ok(C_PUSH, 16'h0005, 16'h0005, 16'h0000, 5'd1);
    cmd_ok(C_PUSH, 16'h000A, 16'h000A, 16'h0005, 5'd2);
    idle_drain("drain_push2");
    cmd_ok(C_REDUZ, 16'h000F, 16'h000F, 16'h0000, 5'd1);
    cmd_ok(C_POP, 16'h0000, 16'h0000, 16'h0000, 5'd0);
    idle_drain("drain_reduz");

    // POP on empty, then clear
    cmd_bad(C_POP, 16'h0000, 1'b0, 16'h0000, 5'd0);
    chk("pop_empty_vazia", {31'h0, vazia}, 32'd1);
    clear_err();

    // Fill to 16, then overflow attempt
    for (int i = 1; i <= 16; i++) begin
      cmd_ok(C_PUSH, 16'(i), 16'(i), 16'(i - 1), 5'(i));
    end
    idle_drain("drain_fill");
    cmd_bad(C_PUSH, 16'hFFFF, 1'b0, 16'h0010, 5'd16);
    chk("full_cheia", {31'h0, cheia}, 32'd1);
    clear_err();

    // Drain completely; entry k holds k+1
    for (int i = 15; i >= 0; i--) begin
      cmd_ok(C_POP, 16'h0000, (i >= 1) ? 16'(i) : 16'h0000,
             (i >= 2) ? 16'(i - 1) : 16'h0000, 5'(i));
    end
    idle_drain("drain_empty");

    // SUBST then rejected REDUZ, with clear losing to the set
    cmd_ok(C_PUSH, 16'h0007, 16'h0007, 16'h0000, 5'd1);
    cmd_ok(C_SUBST, 16'h1234, 16'h1234, 16'h0000, 5'd1);
    idle_drain("drain_subst");
    cmd_bad(C_REDUZ, 16'h5555, 1'b1, 16'h1234, 5'd1);
    clear_err();
    cmd_ok(C_POP, 16'h0000, 16'h0000, 16'h0000, 5'd0);
    idle_drain("drain_pop1");
    cmd_bad(C_SUBST, 16'h0009, 1'b0, 16'h0000, 5'd0);

    // Three entries, then reset lands while a PUSH is being presented
    cmd_ok(C_PUSH, 16'h0001, 16'h0001, 16'h0000, 5'd1);
    cmd_ok(C_PUSH, 16'h0002, 16'h0002, 16'h0001, 5'd2);
    cmd_ok(C_PUSH, 16'h0003, 16'h0003, 16'h0002, 5'd3);
    idle_drain("drain_pre_rst");
    chk("pre_rst_erro", {31'h0, erro}, 32'd1);
    @(negedge clock);
    pilha_wren = 1'b1; controle_pilha = C_PUSH; data_pilha = 16'h0004;
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_cnt", {27'h0, contagem}, 32'd0);
    chk("mid_rst_vazia", {31'h0, vazia}, 32'd1);
    chk("mid_rst_topo", {16'h0, topo}, 32'd0);
    chk("mid_rst_seg", {16'h0, segundo}, 32'd0);
    chk("mid_rst_pronto", {31'h0, pronto}, 32'd0);
    chk("mid_rst_erro", {31'h0, erro}, 32'd0);
    @(negedge clock);
    reset = 1'b1; pilha_wren = 1'b0;
    repeat (2) @(negedge clock);
    chk("post_rst_pronto", {31'h0, pronto}, 32'd0);
    chk("post_rst_cnt", {27'h0, contagem}, 32'd0);
    idle_drain("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
